ripple_count_sequencer: RTL

Synchronous controller that drives an external asynchronous (ripple) up/down counter. It issues single count pulses and waits a programmable settle time after each one for the ripple to finish. It then samples the settled value and stops when a target count is reached. It sits between system-clocked logic and the ripple counter, so the system never reads an unsettled ripple value.

---
 rtl/ripple_seq_pkg.sv | 16 +
 rtl/ripple_settle_timer.sv | 27 ++
 rtl/ripple_count_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ripple_seq_pkg.sv
// Shared types for the ripple counter sequencer: FSM state encoding and
// settle counter width.
package ripple_seq_pkg;

  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PULSE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/ripple_settle_timer.sv
// Loadable down-counter that times the ripple settle window; expired is
// high once the loaded count has run down to zero.
module ripple_settle_timer
  import ripple_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  output logic                expired
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ripple_count_sequencer.sv
// Clock-domain front end for an external ripple up/down counter: pulses it,
// waits for the ripple to settle, samples it and stops at a target value.
// Optional feature: define RCS_CHECK_EN to cross-check samples against a
// synchronous shadow counter (err flag); undefined, err is tied low.
module ripple_count_sequencer
  import ripple_seq_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_up,
  input  logic [WIDTH-1:0] target,
  output logic             cnt_clk,
  output logic             cnt_clr,
  output logic             cnt_dir,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Loaded on the edge that enters SETTLE, so the window lasts SETTLE_CYCLES.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [WIDTH-1:0] target_q;
  logic             settle_load;
  logic             settle_expired;

  assign settle_load = (state == CLEAR) || (state == PULSE);

  ripple_settle_timer u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (settle_load),
    .value   (SETTLE_LOAD),
    .expired (settle_expired)
  );

`ifdef RCS_CHECK_EN
  logic [WIDTH-1:0] shadow;
  logic             mismatch;

  assign mismatch = (cnt_q != shadow);
`else
  assign err = 1'b0;
`endif

  // cnt_q is only sampled in CHECK, after the settle window, so the ripple
  // value is stable there and needs no synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      target_q  <= '0;
      cnt_clk   <= 1'b0;
      cnt_clr   <= 1'b1;
      cnt_dir   <= 1'b1;
      count_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef RCS_CHECK_EN
      err       <= 1'b0;
      shadow    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt_clr <= 1'b0;
          cnt_clk <= 1'b0;
          if (start) begin
            cnt_dir  <= dir_up;
            target_q <= target;
            busy     <= 1'b1;
            cnt_clr  <= 1'b1;
`ifdef RCS_CHECK_EN
            err      <= 1'b0;
`endif
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_clr <= 1'b0;
`ifdef RCS_CHECK_EN
          shadow  <= '0;
`endif
          state   <= SETTLE;
        end
        PULSE: begin
          cnt_clk <= 1'b0;
`ifdef RCS_CHECK_EN
          shadow  <= cnt_dir ? shadow + WIDTH'(1) : shadow - WIDTH'(1);
`endif
          state   <= SETTLE;
        end
        SETTLE: begin
          if (settle_expired) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          count_out <= cnt_q;
`ifdef RCS_CHECK_EN
          if (mismatch) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else
`endif
          if ((cnt_q == target_q) || stop) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt_clk <= 1'b1;
            state   <= PULSE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
